qspi_word_port: RTL

- Word-wide, parametrised memory port between the CPU-side memory control logic and the QSPI byte controller (qspi_ctrl).
- Accepts 1..WORD_BYTES-byte read/write requests and serialises them into byte-level QSPI transactions, little-endian.
- Adds sequential-burst continuation: a QSPI transaction stays open across back-to-back sequential requests, avoiding repeated command/address phases.
- Successor to the current single-byte memory glue.

---
 rtl/qspi_word_port.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/qspi_word_port.sv
// qspi_word_port: word-wide memory port in front of the QSPI byte controller.
// Splits 1..WORD_BYTES-byte requests into little-endian byte transfers. When
// built with QSPI_SEQ_CONTINUE_EN, a transaction is held open (stalled) after
// each response so that a following sequential request of the same direction
// continues without a new command/address phase.
//
// state | meaning
// IDLE  | no transaction open, waiting for a request
// START | q_addr driven, start pulse to the controller
// XFER  | bytes moving, one per controller strobe
// RESP  | one-cycle completion pulse to the requester
// HOLD  | transaction open but stalled, waiting for a sequential request
// STOP  | close pulse to the controller
module qspi_word_port #(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int WORD_BYTES     = 2,
  parameter int ADDRESS_WIDTH  = 24,
  parameter int HOLD_TIMEOUT   = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_write,
  input  logic [ADDRESS_WIDTH-1:0]             req_addr,
  input  logic [2:0]                           req_len,
  input  logic [DATA_BUS_WIDTH*WORD_BYTES-1:0] req_wdata,
  output logic                                 rsp_valid,
  output logic [DATA_BUS_WIDTH*WORD_BYTES-1:0] rsp_rdata,
  output logic [24:0]                          q_addr,
  output logic [DATA_BUS_WIDTH-1:0]            q_data_out,
  output logic                                 q_start_read,
  output logic                                 q_start_write,
  output logic                                 q_stall,
  output logic                                 q_stop,
  input  logic [DATA_BUS_WIDTH-1:0]            q_data_in,
  input  logic                                 q_data_req,
  input  logic                                 q_data_ready,
  output logic                                 busy
);

  localparam int DW  = DATA_BUS_WIDTH * WORD_BYTES;
  localparam int AW1 = ADDRESS_WIDTH + 1;
  localparam int HW  = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_TIMEOUT > 0) ? HOLD_TIMEOUT - 1 : 0);
  localparam logic [2:0]    WB_LEN    = 3'(WORD_BYTES);

`ifdef QSPI_SEQ_CONTINUE_EN
  localparam bit HOLD_PATH = (HOLD_TIMEOUT > 0);
`else
  localparam bit HOLD_PATH = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_XFER, S_HOLD, S_STOP, S_RESP
  } state_t;

  state_t                     r_state;
  logic                       r_req_ready;
  logic                       r_dir;
  logic [ADDRESS_WIDTH-1:0]   r_addr;
  logic [2:0]                 r_len;
  logic [2:0]                 r_cnt;
  logic [DW-1:0]              r_wdata;
  logic [DW-1:0]              r_rbuf;
  logic [DW-1:0]              r_rsp_rdata;
  logic [ADDRESS_WIDTH-1:0]   r_next_addr;
  logic                       r_next_ok;
  logic                       r_pending;
  logic [HW-1:0]              r_idle;
  logic [24:0]                r_q_addr;
  logic                       r_start_rd;
  logic                       r_start_wr;
  logic                       r_stop;

  logic [2:0]                 w_len_eff;
  logic                       w_accept;
  logic                       w_strobe;
  logic                       w_xfer_last;
  logic [AW1-1:0]             w_next_sum;
  logic                       w_seq;
  logic [DATA_BUS_WIDTH-1:0]  w_wbyte;
  logic [DW-1:0]              w_rbuf_next;

  assign w_len_eff   = (req_len == 3'd0 || req_len > WB_LEN) ? WB_LEN : req_len;
  assign w_accept    = req_valid && r_req_ready;
  assign w_strobe    = r_dir ? q_data_req : q_data_ready;
  assign w_xfer_last = (r_state == S_XFER) && w_strobe && (r_cnt == (r_len - 3'd1));
  // A carry out of the address means the next request wrapped; never treat it as sequential.
  assign w_next_sum  = {1'b0, r_addr} + AW1'(r_len);
  assign w_seq       = (req_write == r_dir) && r_next_ok && (req_addr == r_next_addr);

  // Select the outgoing write byte and merge the incoming read byte at the current count.
  always_comb begin
    w_wbyte     = '0;
    w_rbuf_next = r_rbuf;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (r_cnt == 3'(i)) begin
        w_wbyte = r_wdata[i*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
        w_rbuf_next[i*DATA_BUS_WIDTH +: DATA_BUS_WIDTH] = q_data_in;
      end
    end
  end

  // Sequencing FSM with registered handshake and controller pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b0;
      r_dir       <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_wdata     <= '0;
      r_rbuf      <= '0;
      r_rsp_rdata <= '0;
      r_next_addr <= '0;
      r_next_ok   <= 1'b0;
      r_pending   <= 1'b0;
      r_idle      <= '0;
      r_q_addr    <= '0;
      r_start_rd  <= 1'b0;
      r_start_wr  <= 1'b0;
      r_stop      <= 1'b0;
    end else begin
      r_start_rd <= 1'b0;
      r_start_wr <= 1'b0;
      r_stop     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_dir       <= req_write;
            r_addr      <= req_addr;
            r_len       <= w_len_eff;
            r_wdata     <= req_wdata;
            r_cnt       <= '0;
            r_rbuf      <= '0;
            r_q_addr    <= 25'(req_addr);
            r_start_rd  <= !req_write;
            r_start_wr  <= req_write;
            r_req_ready <= 1'b0;
            r_state     <= S_START;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_START: begin
          r_state <= S_XFER;
        end
        S_XFER: begin
          if (w_strobe) begin
            r_cnt <= r_cnt + 3'd1;
            if (!r_dir) r_rbuf <= w_rbuf_next;
            if (w_xfer_last) begin
              r_next_addr <= w_next_sum[ADDRESS_WIDTH-1:0];
              r_next_ok   <= !w_next_sum[ADDRESS_WIDTH];
              r_rsp_rdata <= r_dir ? '0 : w_rbuf_next;
              r_state     <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (HOLD_PATH) begin
            r_idle      <= '0;
            r_req_ready <= 1'b1;
            r_state     <= S_HOLD;
          end else begin
            r_pending <= 1'b0;
            r_stop    <= 1'b1;
            r_state   <= S_STOP;
          end
        end
        S_HOLD: begin
          r_idle <= r_idle + 1'b1;
          if (w_accept) begin
            r_dir       <= req_write;
            r_addr      <= req_addr;
            r_len       <= w_len_eff;
            r_wdata     <= req_wdata;
            r_cnt       <= '0;
            r_rbuf      <= '0;
            r_req_ready <= 1'b0;
            if (w_seq) begin
              r_state <= S_XFER;
            end else begin
              r_pending <= 1'b1;
              r_stop    <= 1'b1;
              r_state   <= S_STOP;
            end
          end else if (r_idle == HOLD_LAST) begin
            r_pending   <= 1'b0;
            r_stop      <= 1'b1;
            r_req_ready <= 1'b0;
            r_state     <= S_STOP;
          end
        end
        S_STOP: begin
          if (r_pending) begin
            r_pending  <= 1'b0;
            r_q_addr   <= 25'(r_addr);
            r_start_rd <= !r_dir;
            r_start_wr <= r_dir;
            r_state    <= S_START;
          end else begin
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_req_ready <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign rsp_valid     = (r_state == S_RESP);
  assign rsp_rdata     = r_rsp_rdata;
  assign q_addr        = r_q_addr;
  assign q_data_out    = (r_state == S_XFER && r_dir) ? w_wbyte : '0;
  assign q_start_read  = r_start_rd;
  assign q_start_write = r_start_wr;
  assign q_stop        = r_stop;
  // Last-byte stall is combinational so the controller moves no extra byte;
  // with continuation the stall also covers RESP and HOLD to keep the transaction paused.
  assign q_stall       = (r_state == S_HOLD) || ((r_state == S_RESP) && HOLD_PATH) || w_xfer_last;
  assign busy          = (r_state != S_IDLE);

endmodule
